// File: rtl/tpu_pkg.sv
// Shared definitions for the C-row requantization unit.
// Holds lane widths, config register addresses, int32 limits and the
// reset defaults of every config register.
package tpu_pkg;

  localparam int unsigned LANES = 4;
  localparam int unsigned ACC_W = 32;
  localparam int unsigned OUT_W = 8;

  // Config register map
  localparam logic [3:0] CFG_BIAS0  = 4'd0;   // 0..3  bias[i]
  localparam logic [3:0] CFG_MULT0  = 4'd4;   // 4..7  mult[i]
  localparam logic [3:0] CFG_SHIFT0 = 4'd8;   // 8..11 shift[i]
  localparam logic [3:0] CFG_OFFSET = 4'd12;
  localparam logic [3:0] CFG_ACT    = 4'd13;
  localparam logic [3:0] CFG_RSVD   = 4'd14;  // 14..15 ignored

  localparam logic [31:0] INT32_MIN = 32'h8000_0000;
  localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;

  // Rounding nudges for the doubling high multiply: 2^30 and 1-2^30
  localparam logic signed [63:0] NUDGE_POS = 64'sh0000_0000_4000_0000;
  localparam logic signed [63:0] NUDGE_NEG = 64'shFFFF_FFFF_C000_0001;

  // Reset defaults
  localparam logic [31:0] BIAS_RST    = 32'h0000_0000;
  localparam logic [31:0] MULT_ONE    = 32'h4000_0000;
  localparam logic [4:0]  SHIFT_RST   = 5'd0;
  localparam logic [8:0]  OFFSET_RST  = 9'd0;
  localparam logic [7:0]  ACT_MIN_RST = 8'h80;
  localparam logic [7:0]  ACT_MAX_RST = 8'h7F;

endpackage

// File: rtl/c_requant_unit_lane.sv
// requant_lane: one accumulator lane of the requantization pipeline.
//   stage 1: saturating bias add
//   stage 2: saturating rounding doubling high multiply
//   stage 3: rounding right shift, output offset, activation clamp
// Ports: clk, rst (async active-high), en (pipeline advance),
//   acc (int32 accumulator), bias/mult/shift (lane config),
//   out_offset/act_min/act_max (shared config), q (int8 result, registered).
module requant_lane
  import tpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] acc,
  input  logic [31:0] bias,
  input  logic [31:0] mult,
  input  logic [4:0]  shift,
  input  logic [8:0]  out_offset,
  input  logic [7:0]  act_min,
  input  logic [7:0]  act_max,
  output logic [7:0]  q
);

  logic signed [31:0] b_q, m_q;
  logic signed [31:0] b_d, m_d;
  logic        [7:0]  q_d;

  // Stage 1: 33-bit sum, saturate when the two top bits disagree
  logic signed [32:0] sum;
  always_comb begin
    sum = {acc[31], acc} + {bias[31], bias};
    if (sum[32] != sum[31]) b_d = sum[32] ? INT32_MIN : INT32_MAX;
    else                    b_d = sum[31:0];
  end

  // Stage 2: biasing a negative value by 2^31-1 before the arithmetic
  // shift turns the floor into a truncation toward zero.
  logic signed [63:0] b64, k64, p, t;
  always_comb begin
    b64 = {{32{b_q[31]}}, b_q};
    k64 = {{32{mult[31]}}, mult};
    p   = b64 * k64;
    t   = p + (p[63] ? NUDGE_NEG : NUDGE_POS);
    if (t[63]) t = t + 64'sh0000_0000_7FFF_FFFF;
    m_d = t[62:31];
    if (b_q == INT32_MIN && mult == INT32_MIN) m_d = INT32_MAX;
  end

  // Stage 3: round half away from zero, offset, min clamp then max clamp
  logic        [31:0] mask, rem, thr;
  logic signed [31:0] m_sh;
  logic               round_up;
  logic signed [32:0] r, v, lo, hi, c;
  always_comb begin
    mask     = (32'd1 << shift) - 32'd1;
    rem      = m_q & mask;
    thr      = {1'b0, mask[31:1]} + {31'b0, m_q[31]};
    round_up = rem > thr;
    m_sh     = m_q >>> shift;
    r        = {m_sh[31], m_sh} + {32'b0, round_up};
    v        = r + {{24{out_offset[8]}}, out_offset};
    lo       = {{25{act_min[7]}}, act_min};
    hi       = {{25{act_max[7]}}, act_max};
    c        = v;
    if (c < lo) c = lo;
    if (c > hi) c = hi;
    q_d      = c[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_q <= '0;
      m_q <= '0;
      q   <= '0;
    end else if (en) begin
      b_q <= b_d;
      m_q <= m_d;
      q   <= q_d;
    end
  end

endmodule

// File: rtl/c_requant_unit.sv
// c_requant_unit: requantizes 128-bit C rows (four int32 lanes) into a
// packed 32-bit word of four int8 results through a 3-stage pipeline.
// Ports: clk; rst_n (async reset, active-HIGH despite the name);
//   cfg_we/cfg_addr/cfg_data config writes, cfg_err pulse on a dropped write;
//   in_valid/in_ready/in_data input row; out_valid/out_ready/out_data result;
//   busy when any pipeline stage holds a row.
module c_requant_unit
  import tpu_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned ACC_W = 32,
  parameter int unsigned OUT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic [3:0]               cfg_addr,
  input  logic [31:0]              cfg_data,
  output logic                     cfg_err,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*ACC_W-1:0]   in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*OUT_W-1:0]   out_data,
  output logic                     busy
);

  logic [31:0] bias  [LANES];
  logic [31:0] mult  [LANES];
  logic [4:0]  shift [LANES];
  logic [8:0]  out_offset;
  logic [7:0]  act_min, act_max;

  logic v1, v2, v3;
  logic advance;

  // The whole pipeline stalls only when the result register is held
  assign advance   = !v3 || out_ready;
  assign in_ready  = advance;
  assign out_valid = v3;
  assign busy      = v1 | v2 | v3;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (advance) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
    end
  end

  // Config is only writable with an empty pipeline so rows in flight
  // never see a mix of old and new settings.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        bias[i]  <= BIAS_RST;
        mult[i]  <= MULT_ONE;
        shift[i] <= SHIFT_RST;
      end
      out_offset <= OFFSET_RST;
      act_min    <= ACT_MIN_RST;
      act_max    <= ACT_MAX_RST;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      if (cfg_we) begin
        if (busy) begin
          cfg_err <= (cfg_addr < CFG_RSVD);
        end else begin
          case (cfg_addr[3:2])
            2'd0: bias[cfg_addr[1:0]]  <= cfg_data;
            2'd1: mult[cfg_addr[1:0]]  <= cfg_data;
            2'd2: shift[cfg_addr[1:0]] <= cfg_data[4:0];
            default: begin
              if (cfg_addr == CFG_OFFSET) begin
                out_offset <= cfg_data[8:0];
              end else if (cfg_addr == CFG_ACT) begin
                act_min <= cfg_data[7:0];
                act_max <= cfg_data[15:8];
              end
            end
          endcase
        end
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [7:0] lane_q;

    requant_lane u_lane (
      .clk        (clk),
      .rst        (rst_n),
      .en         (advance),
      .acc        (in_data[LANES*ACC_W-1-ACC_W*g -: ACC_W]),
      .bias       (bias[g]),
      .mult       (mult[g]),
      .shift      (shift[g]),
      .out_offset (out_offset),
      .act_min    (act_min),
      .act_max    (act_max),
      .q          (lane_q)
    );

    assign out_data[LANES*OUT_W-1-OUT_W*g -: OUT_W] = lane_q;
  end

endmodule

// File: tb/tb_c_requant_unit.sv
// Testbench for c_requant_unit: directed and random rows checked against
// an arithmetic reference model of the requantization rules.
module tb_c_requant_unit;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_we;
  logic [3:0]   cfg_addr;
  logic [31:0]  cfg_data;
  logic         cfg_err;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  c_requant_unit #(.LANES(4), .ACC_W(32), .OUT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_err   (cfg_err),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // ---------------- reference model ----------------
  localparam longint I32MAX = 64'sd2147483647;
  localparam longint I32MIN = -64'sd2147483648;

  int m_bias [4];
  int m_mult [4];
  int m_shift[4];
  int m_off, m_min, m_max;

  logic [127:0] rows[$];
  logic [31:0]  exp_q[$];
  logic [31:0]  last_out;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_bias[i]  = 0;
      m_mult[i]  = 32'h4000_0000;
      m_shift[i] = 0;
    end
    m_off = 0;
    m_min = -128;
    m_max = 127;
  endfunction

  function automatic void model_write(input logic [3:0] a, input logic [31:0] d);
    if (a < 4)       m_bias[a]     = int'($signed(d));
    else if (a < 8)  m_mult[a - 4] = int'($signed(d));
    else if (a < 12) m_shift[a - 8] = int'(d[4:0]);
    else if (a == 12) m_off = int'($signed(d[8:0]));
    else if (a == 13) begin
      m_min = int'($signed(d[7:0]));
      m_max = int'($signed(d[15:8]));
    end
  endfunction

  function automatic logic [7:0] lane_model(input longint acc, input int i);
    longint b, k, p, t, m, mag, r, v, div;
    b = acc + longint'(m_bias[i]);
    if (b > I32MAX) b = I32MAX;
    if (b < I32MIN) b = I32MIN;
    k = longint'(m_mult[i]);
    if (b == I32MIN && k == I32MIN) m = I32MAX;
    else begin
      p = b * k;
      t = p + ((p >= 0) ? 64'sd1073741824 : (64'sd1 - 64'sd1073741824));
      m = t / 64'sd2147483648;  // integer division truncates toward zero
    end
    if (m_shift[i] == 0) r = m;
    else begin
      div = 64'sd1 << m_shift[i];
      mag = (m < 0) ? -m : m;
      r   = (mag + div / 2) / div;
      if (m < 0) r = -r;
    end
    v = r + longint'(m_off);
    if (v < longint'(m_min)) v = longint'(m_min);
    if (v > longint'(m_max)) v = longint'(m_max);
    return v[7:0];
  endfunction

  function automatic logic [31:0] expect_row(input logic [127:0] row);
    logic [31:0] res;
    res = '0;
    for (int i = 0; i < 4; i++)
      res[31-8*i -: 8] = lane_model(longint'($signed(row[127-32*i -: 32])), i);
    return res;
  endfunction

  function automatic logic [127:0] mk_row(input int a, input int b, input int c, input int d);
    return {32'(a), 32'(b), 32'(c), 32'(d)};
  endfunction

  function automatic logic [127:0] rand_row();
    logic [127:0] r;
    for (int i = 0; i < 4; i++)
      r[32*i +: 32] = ($urandom_range(0, 1) == 1) ? $urandom
                                                  : 32'(int'($urandom_range(0, 2000)) - 1000);
    return r;
  endfunction

  // ---------------- drivers ----------------
  task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL cfg_idle_err: got %b want 0", cfg_err);
    end
    model_write(a, d);
  endtask

  // Streams the global rows queue; out_ready low for the first 'stall'
  // cycles, then always high or random. Checks results in order and
  // stability of out_data while held.
  task automatic run_stream(input int stall, input bit rand_ready, input bit cfg_probe,
                            output int acc_at_block);
    int idx, got, cyc, n;
    logic stall_prev;
    logic [31:0] data_prev, e;
    idx = 0; got = 0; cyc = 0; n = rows.size();
    stall_prev = 1'b0; data_prev = '0; acc_at_block = -1;
    exp_q.delete();
    while ((idx < n || got < n) && cyc < 500) begin
      @(negedge clk);
      in_valid  = (idx < n);
      in_data   = (idx < n) ? rows[idx] : '0;
      out_ready = (cyc < stall) ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      if (cfg_probe) begin
        cfg_we   = (cyc == 3);
        cfg_addr = 4'd0;
        cfg_data = 32'h0000_1234;
      end
      #1;
      if (cfg_probe && cyc == 3) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_stall: got %b want 1", busy);
        end
      end
      if (cfg_probe && (cyc == 4 || cyc == 5)) begin
        checks++;
        if (cfg_err !== (cyc == 4)) begin
          errors++;
          $display("FAIL cfg_err_pulse cyc%0d: got %b want %b", cyc, cfg_err, (cyc == 4));
        end
      end
      if (stall_prev) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== data_prev) begin
          errors++;
          $display("FAIL hold_stable: got v=%b d=%h want v=1 d=%h", out_valid, out_data, data_prev);
        end
      end
      if (in_valid && !in_ready && acc_at_block < 0) acc_at_block = idx;
      if (in_valid && in_ready) begin
        exp_q.push_back(expect_row(rows[idx]));
        idx++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_out: got %h want none", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL row%0d_data: got %h want %h", got, out_data, e);
          end
        end
        last_out = out_data;
        got++;
      end
      stall_prev = out_valid && !out_ready;
      data_prev  = out_data;
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1; cfg_we = 1'b0;
    if (idx < n || got < n) begin
      checks++; errors++;
      $display("FAIL stream_timeout: got %0d rows want %0d", got, n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || busy !== 1'b0 || cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got v=%b d=%h busy=%b err=%b want 0 0 0 0",
               out_valid, out_data, busy, cfg_err);
    end
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_identity();
    int blk;
    rows.delete();
    rows.push_back(mk_row(100, -5, 127, -200));
    run_stream(0, 1'b0, 1'b0, blk);
    // Default mult is 0.5 in Q31: {50, -2, 64, -100}
    checks++;
    if (last_out !== 32'h32FE_409C) begin
      errors++;
      $display("FAIL identity_const: got %h want 32fe409c", last_out);
    end
  endtask

  task automatic test_bias_shift();
    int blk;
    cfg_write(4'd0, 32'd28);
    cfg_write(4'd8, 32'd2);
    cfg_write(4'd9, 32'd2);
    cfg_write(4'd10, 32'd2);
    rows.delete();
    rows.push_back(mk_row(100, 6, -6, 0));
    rows.push_back(mk_row(5, 7, -7, 3));
    rows.push_back(mk_row(2, -2, 10, -10));
    for (int i = 0; i < 5; i++) rows.push_back(rand_row());
    run_stream(0, 1'b0, 1'b0, blk);
  endtask

  task automatic test_srdhm_sat();
    int blk;
    cfg_write(4'd0, 32'd0);
    cfg_write(4'd8, 32'd0);
    cfg_write(4'd4, 32'h8000_0000);
    rows.delete();
    rows.push_back(mk_row(int'(32'h8000_0000), 1, 2, 3));
    run_stream(0, 1'b0, 1'b0, blk);
    checks++;
    if (last_out[31:24] !== 8'h7F) begin
      errors++;
      $display("FAIL srdhm_min_min: got %h want 7f", last_out[31:24]);
    end
    cfg_write(4'd4, 32'h4000_0000);
    cfg_write(4'd0, 32'd1);
    rows.delete();
    rows.push_back(mk_row(int'(32'h7FFF_FFFF), 0, 0, 0));
    run_stream(0, 1'b0, 1'b0, blk);
    checks++;
    if (last_out[31:24] !== 8'h7F) begin
      errors++;
      $display("FAIL bias_sat: got %h want 7f", last_out[31:24]);
    end
  endtask

  task automatic test_offset_act();
    int blk;
    cfg_write(4'd12, 32'h0000_0180);           // -128
    cfg_write(4'd13, {16'h0, 8'h00, 8'h80});   // min -128, max 0
    rows.delete();
    rows.push_back(mk_row(200, 50, 0, 300));
    rows.push_back(mk_row(-300, 256, 255, -1));
    run_stream(0, 1'b0, 1'b0, blk);
    cfg_write(4'd13, {16'h0, 8'hF6, 8'h14});   // min 20 > max -10
    rows.delete();
    for (int i = 0; i < 4; i++) rows.push_back(rand_row());
    run_stream(0, 1'b0, 1'b0, blk);
  endtask

  task automatic test_random();
    int blk;
    for (int pass = 0; pass < 3; pass++) begin
      for (int a = 0; a < 4; a++) begin
        cfg_write(4'(a), 32'(int'($urandom_range(0, 4000)) - 2000));
        cfg_write(4'(a + 4), (pass == 2) ? $urandom : (32'h2000_0000 + $urandom_range(0, 32'h5FFF_FFFF)));
        cfg_write(4'(a + 8), 32'($urandom_range(0, 12)));
      end
      cfg_write(4'd12, 32'($urandom_range(0, 511)));
      cfg_write(4'd13, {16'h0, 8'($urandom_range(20, 127)), 8'($urandom_range(128, 240))});
      rows.delete();
      for (int i = 0; i < 12; i++) rows.push_back(rand_row());
      run_stream(0, 1'b1, 1'b0, blk);
    end
  endtask

  task automatic test_back_to_back();
    int blk;
    rows.delete();
    for (int i = 0; i < 6; i++) rows.push_back(rand_row());
    run_stream(5, 1'b0, 1'b1, blk);
    checks++;
    if (blk != 3) begin
      errors++;
      $display("FAIL accept_before_block: got %0d want 3", blk);
    end
  endtask

  task automatic test_reset_mid();
    int blk;
    logic [127:0] ra;
    cfg_write(4'd0, 32'd5);
    ra = mk_row(1000, -1000, 77, -77);
    @(negedge clk); in_valid = 1'b1; in_data = ra; out_ready = 1'b1;
    @(negedge clk); in_data = mk_row(1, 2, 3, 4);
    @(posedge clk); in_valid = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: got v=%b busy=%b d=%h want 0 0 0", out_valid, busy, out_data);
    end
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    rows.delete();
    rows.push_back(ra);
    run_stream(0, 1'b0, 1'b0, blk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1; last_out = '0;
    model_reset();
    test_reset();
    test_identity();
    test_bias_shift();
    test_srdhm_sat();
    test_offset_act();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
